// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with 2-entry prefetch queue
// Shares the single Imem read port between sequential fetch and debug reads.
module imem_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_a,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_q_addr [2];
  logic [DATA_W-1:0] r_q_data [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_last_dbg;

  logic              w_pop;
  logic              w_fetch_want;
  logic              w_dbg_gnt;
  logic              w_fetch_gnt;
  logic [1:0]        w_count_next;

  assign inst_valid   = (r_count != 2'd0);
  assign inst_addr    = r_q_addr[r_rptr];
  assign inst_data    = r_q_data[r_rptr];
  assign w_pop        = inst_valid & inst_ready;
  assign w_fetch_want = (r_count < 2'd2) | w_pop;

  // Alternating priority: after a debug grant, fetch wins the next contended cycle.
  assign w_dbg_gnt    = dbg_req & ~r_dbg_ack & (~w_fetch_want | ~r_last_dbg);
  assign w_fetch_gnt  = w_fetch_want & ~w_dbg_gnt & ~redirect_valid;

  assign imem_a       = w_dbg_gnt ? dbg_addr : r_fpc;
  assign dbg_ack      = r_dbg_ack;
  assign dbg_data     = r_dbg_data;

  assign w_count_next = r_count + {1'b0, w_fetch_gnt} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc      <= RESET_PC;
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= '0;
      r_last_dbg <= 1'b0;
    end else begin
      r_dbg_ack  <= w_dbg_gnt;
      r_last_dbg <= w_dbg_gnt;
      if (w_dbg_gnt) begin
        r_dbg_data <= imem_rd;
      end
      // Redirect overrides any pop or push in the same cycle.
      if (redirect_valid) begin
        r_fpc   <= redirect_addr;
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_fetch_gnt) begin
          r_fpc  <= r_fpc + PC_INC;
          r_wptr <= ~r_wptr;
        end
        if (w_pop) begin
          r_rptr <= ~r_rptr;
        end
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fetch_gnt) begin
      r_q_addr[r_wptr] <= r_fpc;
      r_q_data[r_wptr] <= imem_rd;
    end
  end

endmodule
